systolic_tile_scheduler: RTL and testbench

// Sequences one output tile through SystolicArray: clears accumulators, fetches operand

---
 rtl/systolic_tile_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler.sv
// Tile sequencer for an N x N output-stationary systolic array: clears the accumulators,
// fetches A/B operand vectors, applies the diagonal input skew, drains the wavefront, pulses done.
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

package systolic_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic        valid;
  } scalar_t;
endpackage

module systolic_tile_scheduler
  import systolic_pkg::*;
#(
  parameter int N     = `SYS_ARRAY_LEN,
  parameter int K_MAX = 64,
  parameter int KW    = $clog2(K_MAX + 1),
  parameter int DRAIN = 2 * N - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            rd_en,
  output logic [KW-1:0]   rd_idx,
  input  logic [N*32-1:0] a_rd_data,
  input  logic [N*32-1:0] b_rd_data,
  output scalar_t [N-1:0] row,
  output scalar_t [N-1:0] column,
  output logic            clear,
  output logic            done
);
  localparam int TW = $clog2(K_MAX + N + DRAIN + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [TW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_rd_en;
  logic [KW-1:0]   r_rd_idx;
  logic            r_clear;
  logic            r_done;

  logic            w_flush;
  logic [KW-1:0]   w_k_sat;
  logic [TW-1:0]   w_k_ext;
  logic [TW-1:0]   w_feed_last;
  logic [TW-1:0]   w_next_idx;
  logic            w_feed_v;
  scalar_t [N-1:0] w_a_in;
  scalar_t [N-1:0] w_b_in;

  // Abort only acts on a running tile; in IDLE it merely suppresses a same-cycle start.
  assign w_flush     = !rst_n || (abort && (r_state != S_IDLE));
  assign w_k_sat     = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign w_k_ext     = TW'(r_k);
  assign w_feed_last = w_k_ext + TW'(N) - TW'(2);
  assign w_next_idx  = r_cnt + TW'(2);
  assign w_feed_v    = (r_state == S_FEED) && (r_cnt < w_k_ext);

  always_comb begin
    // NOTE: whole vectors get a default first, so no path leaves a bit unassigned (no latch).
    w_a_in = '0;
    w_b_in = '0;
    for (int i = 0; i < N; i++) begin
      if (w_feed_v) begin
        w_a_in[i].data  = a_rd_data[32*i +: 32];
        w_a_in[i].valid = 1'b1;
        w_b_in[i].data  = b_rd_data[32*i +: 32];
        w_b_in[i].valid = 1'b1;
      end
    end
  end

  assign row[0]    = w_a_in[0];
  assign column[0] = w_b_in[0];

  for (genvar i = 1; i < N; i++) begin : g_skew
    scalar_t [i-1:0] r_a_sr;
    scalar_t [i-1:0] r_b_sr;

    always_ff @(posedge clk) begin
      // NOTE: the delay lines are storage but still get flushed: a restarted tile must never see stale operands.
      if (w_flush) begin
        r_a_sr <= '0;
        r_b_sr <= '0;
      end else begin
        r_a_sr[0] <= w_a_in[i];
        r_b_sr[0] <= w_b_in[i];
        for (int s = 1; s < i; s++) begin
          r_a_sr[s] <= r_a_sr[s-1];
          r_b_sr[s] <= r_b_sr[s-1];
        end
      end
    end

    assign row[i]    = r_a_sr[i-1];
    assign column[i] = r_b_sr[i-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (w_flush) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_rd_idx <= '0;
      r_clear  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_clear  <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_rd_idx <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_k     <= w_k_sat;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_clear <= 1'b1;
            r_rd_en <= (w_k_sat != '0);
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt <= '0;
          if (r_k == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_FEED;
            if (r_k > KW'(1)) begin
              r_rd_en  <= 1'b1;
              r_rd_idx <= KW'(1);
            end
          end
        end
        S_FEED: begin
          if (r_cnt == w_feed_last) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + TW'(1);
            // Read one ahead: the buffer answers a cycle after the strobe.
            if (w_next_idx < w_k_ext) begin
              r_rd_en  <= 1'b1;
              r_rd_idx <= KW'(w_next_idx);
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == TW'(DRAIN - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign rd_en  = r_rd_en;
  assign rd_idx = r_rd_idx;
  assign clear  = r_clear;
  assign done   = r_done;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler: operand-buffer model, integer output-stationary
// array model, and cycle-exact checks of strobes, skewed lanes and tile results.
module tb_systolic_tile_scheduler;
  import systolic_pkg::*;

  localparam int N     = 4;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, rd_en, clear, done;
  logic [KW-1:0]   rd_idx;
  logic [N*32-1:0] a_rd_data, b_rd_data;
  scalar_t [N-1:0] row, column;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned mem_a [N][K_MAX];
  int unsigned mem_b [K_MAX][N];

  always #5 clk = ~clk;

  systolic_tile_scheduler #(.N(N), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .rd_en(rd_en), .rd_idx(rd_idx),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .row(row), .column(column), .clear(clear), .done(done)
  );

  // Operand buffers: one-cycle read latency, junk on the bus when not read.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en && rd_idx < KW'(K_MAX)) begin
        a_rd_data[32*i +: 32] <= mem_a[i][rd_idx];
        b_rd_data[32*i +: 32] <= mem_b[rd_idx][i];
      end else begin
        a_rd_data[32*i +: 32] <= 32'hBAD0_0000 + i;
        b_rd_data[32*i +: 32] <= 32'hBEE0_0000 + i;
      end
    end
  end

  // Array model: operands hop one PE per cycle right (A) and down (B); lanes treated as integers.
  scalar_t ea [N][N+1];
  scalar_t eb [N+1][N];
  scalar_t ra [N][N];
  scalar_t rb [N][N];
  longint  acc [N][N];
  logic    skew_now;
  int      skew_err = 0;

  always_comb begin
    ea = '{default: '0};
    eb = '{default: '0};
    skew_now = 1'b0;
    for (int i = 0; i < N; i++) begin
      ea[i][0] = row[i];
      eb[0][i] = column[i];
      for (int j = 0; j < N; j++) begin
        ea[i][j+1] = ra[i][j];
        eb[i+1][j] = rb[i][j];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (ea[i][j].valid != eb[i][j].valid) skew_now = 1'b1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ra[i][j] <= ea[i][j];
        rb[i][j] <= eb[i][j];
        if (clear) acc[i][j] <= 0;
        else if (ea[i][j].valid && eb[i][j].valid)
          acc[i][j] <= acc[i][j] + longint'(ea[i][j].data) * longint'(eb[i][j].data);
      end
    end
    skew_err <= clear ? 0 : skew_err + int'(skew_now);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic scalar_t exp_row(int i, int t, int ke);
    scalar_t s = '0;
    if (t - i >= 0 && t - i < ke) begin
      s.data  = mem_a[i][t-i];
      s.valid = 1'b1;
    end
    return s;
  endfunction

  function automatic scalar_t exp_col(int j, int t, int ke);
    scalar_t s = '0;
    if (t - j >= 0 && t - j < ke) begin
      s.data  = mem_b[t-j][j];
      s.valid = 1'b1;
    end
    return s;
  endfunction

  function automatic longint exp_out(int i, int j, int ke);
    longint s = 0;
    for (int k = 0; k < ke; k++) s += longint'(mem_a[i][k]) * longint'(mem_b[k][j]);
    return s;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_idx"}, rd_idx, 0);
    check({tag, "_clear"}, clear, 0);
    check({tag, "_done"}, done, 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_row%0d", tag, i), row[i], 0);
      check($sformatf("%s_col%0d", tag, i), column[i], 0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
  task automatic run_tile(input int k, input string tag);
    int ke, c, done_cyc, exp_done;
    ke = (k > K_MAX) ? K_MAX : k;
    exp_done = (ke == 0) ? 2 : ke + 3 * N;
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = '0;
    c = 1;
    done_cyc = 0;
    while (done_cyc == 0 && c < 300) begin
      check($sformatf("%s_busy_c%0d", tag, c), busy, 1);
      check($sformatf("%s_clear_c%0d", tag, c), clear, c == 1);
      check($sformatf("%s_rd_en_c%0d", tag, c), rd_en, (c - 1) < ke);
      if (rd_en) check($sformatf("%s_rd_idx_c%0d", tag, c), rd_idx, c - 1);
      for (int i = 0; i < N; i++) begin
        check($sformatf("%s_row%0d_c%0d", tag, i, c), row[i], exp_row(i, c - 2, ke));
        check($sformatf("%s_col%0d_c%0d", tag, i, c), column[i], exp_col(i, c - 2, ke));
      end
      if (done) done_cyc = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    if (done_cyc != 0) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          check($sformatf("%s_out%0d%0d", tag, i, j), acc[i][j], exp_out(i, j, ke));
      check({tag, "_skew"}, skew_err, 0);
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
  endtask

  task automatic load_const(input int unsigned a, input int unsigned b);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        mem_a[i][k] = a;
        mem_b[k][i] = b;
      end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        mem_a[i][k] = i + 1;
        mem_b[k][i] = k;
      end
  endtask

  task automatic load_set(input int sel);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        mem_a[i][k] = (sel == 0) ? (i + k + 1) : ((k % 5) + 2 * i + 1);
        mem_b[k][i] = (sel == 0) ? ((k % 3) + i + 1) : (i + 1 + (k % 2));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-step reduction: 5*3.
    load_const(5, 3);
    run_tile(1, "k1");

    // Ramp operands: out[i][j] = 3*(i+1).
    load_ramp();
    run_tile(3, "k3");

    // Empty reduction: clear then done, no reads, zero results.
    run_tile(0, "k0");

    // start during FEED is ignored; abort at FEED t=2.
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_clear", clear, 0);
    check("ign_busy", busy, 1);
    check("ign_row2", row[2], exp_row(2, 2, 3));
    check("ign_col1", column[1], exp_col(1, 2, 3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      check_idle($sformatf("abort_after%0d", c));
    end
    abort = 1'b1;
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort_start_idle");
    @(negedge clk);
    run_tile(3, "restart");

    // Reset mid-FEED.
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("midreset");
    rst_n = 1'b1;
    for (int c = 0; c < 3 * N + 4; c++) begin
      @(negedge clk);
      check($sformatf("midreset_nodone%0d", c), done, 0);
      check($sformatf("midreset_busy%0d", c), busy, 0);
    end
    run_tile(2, "post_reset");

    // Full-depth tiles back to back, then an over-range length that saturates.
    load_set(0);
    run_tile(K_MAX, "kmax_a");
    load_set(1);
    run_tile(K_MAX, "kmax_b");
    run_tile(100, "ksat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
